// File: rtl/caliptra_prim_sync_reqack_tx.sv
// Source-side end of a bundled-data req/ack CDC handshake.
// Supports 2-phase (toggle) and 4-phase (return-to-zero) signalling with error and timeout pulses.
module caliptra_prim_sync_reqack_tx #(
  parameter int unsigned DataWidth     = 32,
  parameter bit          FourPhase     = 1'b0,
  parameter int unsigned NumSyncStages = 2,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DataWidth-1:0] src_data_i,
  output logic                 req_o,
  output logic [DataWidth-1:0] data_o,
  input  logic                 ack_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    WaitHi = 2'd1,
    WaitLo = 2'd2
  } state_e;

  localparam bit              TimeoutEn = (TimeoutCycles != 0);
  localparam int unsigned     CntW      = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntMax    = CntW'(TimeoutCycles);

  state_e                   state_q, state_d;
  logic [NumSyncStages-1:0] sync_q, sync_d;
  logic                     ack_prev_q;
  logic                     req_q, req_d;
  logic [DataWidth-1:0]     data_q, data_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     timeout_q, timeout_d;
  logic [CntW-1:0]          cnt_q, cnt_d;

  logic ack_s;
  logic accept;
  logic ack_rise;
  logic ack_fall;

  assign ack_s       = sync_q[NumSyncStages-1];
  assign src_ready_o = (state_q == Idle);
  assign accept      = src_valid_i && src_ready_o;
  assign ack_rise    = ack_s && !ack_prev_q;
  assign ack_fall    = !ack_s && ack_prev_q;

  always_comb begin
    sync_d    = {sync_q[NumSyncStages-2:0], ack_i};
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = '0;

    // In 2-phase mode WaitHi is the single wait state; WaitLo is only used by 4-phase.
    unique case (state_q)
      Idle: begin
        if (accept) begin
          data_d  = src_data_i;
          req_d   = FourPhase ? 1'b1 : ~req_q;
          state_d = WaitHi;
        end
      end
      WaitHi: begin
        if (FourPhase) begin
          if (ack_s) begin
            req_d   = 1'b0;
            state_d = WaitLo;
          end
        end else if (ack_s == req_q) begin
          state_d = Idle;
        end
      end
      WaitLo: begin
        if (!ack_s) begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    done_d = (state_q != Idle) && (state_d == Idle);

    if (FourPhase) begin
      err_d = (((state_q == Idle) || (state_q == WaitLo)) && ack_rise) ||
              ((state_q == WaitHi) && ack_fall);
    end else begin
      err_d = (state_q == Idle) && (ack_rise || ack_fall);
    end

    // The counter saturates at its limit so the timeout fires once per transfer.
    if (TimeoutEn && (state_q != Idle) && (state_d != Idle)) begin
      cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
      timeout_d = (cnt_q == CntMax - CntW'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      sync_q     <= '0;
      ack_prev_q <= 1'b0;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      ack_prev_q <= ack_s;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_o     = req_q;
  assign data_o    = data_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign timeout_o = timeout_q;

endmodule
